dco_clkgen_multi: RTL and testbench
===================================

Name: dco_clkgen_multi

Overview:
- Synthesizable, multi-channel successor to the ring-oscillator DCO: N independent digitally controlled clock outputs derived from one system clock.
- Each channel has a W-bit control word (alpha) setting the half-period in clk cycles, plus an optional F-bit fractional word that dithers the half-period via an accumulator.
- Control changes are glitch-free: adopted only at period boundaries.
- Enable stops the output cleanly at the end of the current period.

Parameters:
- N, 2, number of output channels.
- W, 7, alpha width (integer half-period, in clk cycles).
- F, 4, fractional word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  N  per-channel enable (E).
- alpha  in  N*W  per-channel integer half-period; channel c at [c*W +: W].
- frac  in  N*F  per-channel fractional half-period; channel c at [c*F +: F].
- mode  in  N  per-channel mode: 0 = integer, 1 = fractional.
- clk_out  out  N  generated clocks (registered).
- active  out  N  1 while channel is running.
- upd  out  N  1-cycle pulse when new control values are adopted.

Behaviour:
- Reset: clk_out=0, active=0, upd=0, counters=0, accumulators=0, shadow regs=0, all channels IDLE. Reset mid-operation takes effect on the next edge with no partial period.
- Per-channel FSM, states IDLE / HIGH / LOW.
- IDLE:
  - clk_out=0, active=0.
  - en sampled 1 at edge k: at k+1, clk_out=1, state=HIGH, cnt=0, active=1, acc=0.
  - Also at k+1: shadow <= {alpha, frac, mode} and upd=1.
- Half-period start (entry to HIGH or LOW): compute length h.
  - alpha_eff = (alpha_sh==0) ? 1 : alpha_sh.
  - mode_sh=1: {carry, acc} = acc + frac_sh (F+1-bit sum); h = alpha_eff + carry.
  - mode_sh=0: h = alpha_eff; acc is not updated.
  - cnt is W bits. The maximum terminal value is 2^W-1 (when h = 2^W), so no overflow.
- Terminal condition: cnt == h-1; otherwise cnt increments.
- At terminal in HIGH: clk_out <= 0, state <= LOW, cnt <= 0, new h computed.
- At terminal in LOW:
  - en=1: clk_out <= 1, state <= HIGH, cnt <= 0, shadow re-latched. upd=1 only if the new {alpha, frac, mode} differs from the old shadow.
  - en=0: state <= IDLE, clk_out stays 0, active <= 0.
- Changes to alpha/frac/mode mid-period are ignored until the next LOW->HIGH boundary.
- Deasserting en mid-period does not truncate: the high and low phases both complete.
- Re-asserting en during the LOW phase of a stopping period continues seamlessly (en is only sampled at the terminal).
- Channels are fully independent; simultaneous events on different channels do not interact.
- Output latency: 1 clk from en sample to the first rising edge of clk_out.
- No combinational path from inputs to outputs.

Decomposition:
- Package dco_pkg:
  - state enum {IDLE, HIGH, LOW};
  - default W/F/N constants;
  - function alpha_eff().
- Sub-module dco_chan implements one channel (FSM, counter, accumulator, shadow regs).
- Top-level dco_clkgen_multi generates N instances and slices the buses.

Test Plan:
- Integer, alpha=1: rst, en[0]=1, alpha=1, mode=0 -> clk_out[0] rises 1 cycle after en, then toggles every cycle (period 2 clk); upd pulses once at start.
- Integer change at boundary: alpha=3, then alpha=5 written mid-HIGH -> current period 3 high / 3 low; next period 5/5; upd pulses at that rising edge only.
- Fractional: alpha=2, frac=8, mode=1, F=4 -> half-periods 2,3,2,3,...; average period 5 clk over 20 periods.
- Clean stop: en dropped 1 cycle into HIGH with alpha=4 -> high phase 4 cycles, low phase 4 cycles, then active=0 and clk_out stays 0; no runt pulse.
- Extremes: alpha=0 -> behaves as alpha=1; alpha=127 -> 127-cycle half-periods; mode=1 with frac=15 -> 15 of every 16 half-periods are 128 cycles, with no counter overflow.
- Reset and independence: rst mid-HIGH -> next edge all outputs 0. Then ch0 alpha=2 and ch1 alpha=3 (mode=1, frac=4) enabled in the same cycle -> each matches its own expected waveform, unaffected by the other.

Source files
------------

// File: rtl/dco_clkgen_multi_pkg.sv
// Shared types and defaults for the multi-channel clock generator.
// Half-period lengths are counted in system-clock cycles.
package dco_pkg;

  localparam int DCO_N = 2;
  localparam int DCO_W = 7;
  localparam int DCO_F = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } dco_state_e;

  // A zero control word would mean a zero-length half-period, so it is clamped to one cycle.
  function automatic int unsigned alpha_eff(input int unsigned a);
    return (a == 0) ? 32'd1 : a;
  endfunction

endpackage

// File: rtl/dco_clkgen_multi_if.sv
// Control and status bundle for all channels; channel c owns alpha[c*W +: W] and frac[c*F +: F].
interface dco_clkgen_multi_if
  import dco_pkg::*;
#(
  parameter int N = DCO_N,
  parameter int W = DCO_W,
  parameter int F = DCO_F
);

  logic [N-1:0]   en;
  logic [N*W-1:0] alpha;
  logic [N*F-1:0] frac;
  logic [N-1:0]   mode;
  logic [N-1:0]   clk_out;
  logic [N-1:0]   active;
  logic [N-1:0]   upd;

  modport master (
    output en, alpha, frac, mode,
    input  clk_out, active, upd
  );

  modport slave (
    input  en, alpha, frac, mode,
    output clk_out, active, upd
  );

endinterface

// File: rtl/dco_clkgen_multi_chan.sv
// One generated-clock channel: IDLE/HIGH/LOW FSM, half-period counter,
// fractional dither accumulator and control shadow registers.
module dco_chan
  import dco_pkg::*;
#(
  parameter int W = DCO_W,
  parameter int F = DCO_F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_alpha,
  input  logic [F-1:0] i_frac,
  input  logic         i_mode,
  output logic         o_clk_out,
  output logic         o_active,
  output logic         o_upd
);

  dco_state_e   r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_term;
  logic [F-1:0] r_acc;
  logic [W-1:0] r_alpha_sh;
  logic [F-1:0] r_frac_sh;
  logic         r_mode_sh;
  logic         r_clk_out;
  logic         r_active;
  logic         r_upd;

  logic [W-1:0] w_sel_alpha;
  logic [F-1:0] w_sel_frac;
  logic         w_sel_mode;
  logic [F-1:0] w_acc_base;
  logic [F:0]   w_sum;
  logic         w_carry;
  logic [F-1:0] w_acc_next;
  logic [W-1:0] w_term;
  logic         w_at_term;
  logic         w_ctrl_changed;

  // Length of the half-period about to start. Entering LOW uses the shadow;
  // entering HIGH uses the live inputs, which are latched into the shadow on that same edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sel_alpha = i_alpha;
    w_sel_frac  = i_frac;
    w_sel_mode  = i_mode;
    w_acc_base  = r_acc;
    if (r_state == HIGH) begin
      w_sel_alpha = r_alpha_sh;
      w_sel_frac  = r_frac_sh;
      w_sel_mode  = r_mode_sh;
    end
    if (r_state == IDLE) begin
      w_acc_base = '0;
    end
    w_sum      = {1'b0, w_acc_base} + {1'b0, w_sel_frac};
    w_carry    = w_sel_mode & w_sum[F];
    w_acc_next = w_sel_mode ? w_sum[F-1:0] : w_acc_base;
    w_term     = W'(alpha_eff(32'(w_sel_alpha)) - 32'd1 + {31'd0, w_carry});
  end

  assign w_at_term      = (r_cnt == r_term);
  assign w_ctrl_changed = ({i_alpha, i_frac, i_mode} != {r_alpha_sh, r_frac_sh, r_mode_sh});

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_term     <= '0;
      r_acc      <= '0;
      r_alpha_sh <= '0;
      r_frac_sh  <= '0;
      r_mode_sh  <= 1'b0;
      r_clk_out  <= 1'b0;
      r_active   <= 1'b0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_en) begin
            r_state    <= HIGH;
            r_clk_out  <= 1'b1;
            r_active   <= 1'b1;
            r_cnt      <= '0;
            r_term     <= w_term;
            r_acc      <= w_acc_next;
            r_alpha_sh <= i_alpha;
            r_frac_sh  <= i_frac;
            r_mode_sh  <= i_mode;
            r_upd      <= 1'b1;
          end
        end
        HIGH: begin
          if (w_at_term) begin
            r_state   <= LOW;
            r_clk_out <= 1'b0;
            r_cnt     <= '0;
            r_term    <= w_term;
            r_acc     <= w_acc_next;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        LOW: begin
          if (w_at_term) begin
            r_cnt <= '0;
            if (i_en) begin
              r_state    <= HIGH;
              r_clk_out  <= 1'b1;
              r_term     <= w_term;
              r_acc      <= w_acc_next;
              r_alpha_sh <= i_alpha;
              r_frac_sh  <= i_frac;
              r_mode_sh  <= i_mode;
              r_upd      <= w_ctrl_changed;
            end else begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_out <= 1'b0;
          r_active  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_active  = r_active;
  assign o_upd     = r_upd;

endmodule

// File: rtl/dco_clkgen_multi.sv
// N independent digitally controlled clock outputs from one system clock;
// each channel is a dco_chan fed from its slice of the shared control bus.
module dco_clkgen_multi
  import dco_pkg::*;
#(
  parameter int N = DCO_N,
  parameter int W = DCO_W,
  parameter int F = DCO_F
) (
  input  logic               clk,
  input  logic               rst,
  dco_clkgen_multi_if.slave  bus
);

  logic [N-1:0] w_clk_out;
  logic [N-1:0] w_active;
  logic [N-1:0] w_upd;

  for (genvar c = 0; c < N; c++) begin : g_chan
    dco_chan #(
      .W (W),
      .F (F)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en[c]),
      .i_alpha   (bus.alpha[c*W +: W]),
      .i_frac    (bus.frac[c*F +: F]),
      .i_mode    (bus.mode[c]),
      .o_clk_out (w_clk_out[c]),
      .o_active  (w_active[c]),
      .o_upd     (w_upd[c])
    );
  end

  assign bus.clk_out = w_clk_out;
  assign bus.active  = w_active;
  assign bus.upd     = w_upd;

endmodule

// File: tb/tb_dco_clkgen_multi.sv
// Directed bench for dco_clkgen_multi: inputs change on falling edges,
// outputs are sampled on falling edges, half-periods are hand-derived.
module tb_dco_clkgen_multi;

  localparam int N = 2;
  localparam int W = 7;
  localparam int F = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   upd_cnt;

  dco_clkgen_multi_if #(.N(N), .W(W), .F(F)) bus ();

  dco_clkgen_multi #(.N(N), .W(W), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int a, input int f, input logic m, input logic e);
    bus.alpha[ch*W +: W] = W'(a);
    bus.frac[ch*F +: F]  = F'(f);
    bus.mode[ch]         = m;
    bus.en[ch]           = e;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.en    = '0;
    bus.alpha = '0;
    bus.frac  = '0;
    bus.mode  = '0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    upd_cnt = 0;
  endtask

  // Samples len cycles and requires clk_out[ch] to hold lvl in every one of them.
  task automatic phase(input int ch, input logic lvl, input int len, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (bus.clk_out[ch] === lvl) n++;
      if (bus.upd[ch] === 1'b1) upd_cnt++;
    end
    check(tag, 32'(n), 32'(len));
  endtask

  initial begin
    int lvl_q [N];
    int rem_q [N];
    int idx_q [N];
    int bad_q [N];
    tests   = 0;
    fails   = 0;
    upd_cnt = 0;
    rst     = 1'b1;

    // Reset state
    do_reset();
    check("reset_clk_out", 32'(bus.clk_out), 32'd0);
    check("reset_active", 32'(bus.active), 32'd0);
    check("reset_upd", 32'(bus.upd), 32'd0);

    // Integer alpha=1: rises one edge after en, period 2
    set_ch(0, 1, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 1, "a1_first_high");
    check("a1_active", 32'(bus.active[0]), 32'd1);
    check("a1_ch1_idle", 32'(bus.clk_out[1]), 32'd0);
    phase(0, 1'b0, 1, "a1_low0");
    phase(0, 1'b1, 1, "a1_high1");
    phase(0, 1'b0, 1, "a1_low1");
    bus.en[0] = 1'b0;
    phase(0, 1'b0, 3, "a1_stopped");
    check("a1_active_off", 32'(bus.active[0]), 32'd0);
    check("a1_upd_once", 32'(upd_cnt), 32'd1);

    // alpha 3 -> 5 written mid-HIGH takes effect at next rising edge
    do_reset();
    set_ch(0, 3, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 1, "chg_high3_a");
    bus.alpha[0*W +: W] = 7'd5;
    phase(0, 1'b1, 2, "chg_high3_b");
    phase(0, 1'b0, 3, "chg_low3");
    check("chg_upd_before", 32'(upd_cnt), 32'd1);
    phase(0, 1'b1, 5, "chg_high5");
    check("chg_upd_at_edge", 32'(upd_cnt), 32'd2);
    phase(0, 1'b0, 5, "chg_low5");
    phase(0, 1'b1, 5, "chg_high5_b");
    check("chg_upd_steady", 32'(upd_cnt), 32'd2);

    // Clean stop: en dropped one cycle into HIGH, alpha=4
    do_reset();
    set_ch(0, 4, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 1, "stop_high_a");
    bus.en[0] = 1'b0;
    phase(0, 1'b1, 3, "stop_high_b");
    phase(0, 1'b0, 4, "stop_low");
    @(negedge clk);
    check("stop_active_off", 32'(bus.active[0]), 32'd0);
    check("stop_clk_low", 32'(bus.clk_out[0]), 32'd0);
    phase(0, 1'b0, 8, "stop_no_runt");

    // Re-enable during the LOW phase of a stopping period continues seamlessly
    do_reset();
    set_ch(0, 2, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 1, "reen_high_a");
    bus.en[0] = 1'b0;
    phase(0, 1'b1, 1, "reen_high_b");
    phase(0, 1'b0, 1, "reen_low_a");
    bus.en[0] = 1'b1;
    phase(0, 1'b0, 1, "reen_low_b");
    phase(0, 1'b1, 2, "reen_high2");
    check("reen_active", 32'(bus.active[0]), 32'd1);
    check("reen_upd_once", 32'(upd_cnt), 32'd1);

    // Fractional: alpha=2 frac=8 -> 2,3,2,3,... over 20 periods
    do_reset();
    set_ch(0, 2, 8, 1'b1, 1'b1);
    for (int p = 0; p < 20; p++) begin
      phase(0, 1'b1, 2, "frac_high2");
      phase(0, 1'b0, 3, "frac_low3");
    end

    // alpha=0 behaves as alpha=1
    do_reset();
    set_ch(0, 0, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 1, "a0_high");
    phase(0, 1'b0, 1, "a0_low");
    phase(0, 1'b1, 1, "a0_high_b");
    phase(0, 1'b0, 1, "a0_low_b");

    // alpha=127 integer
    do_reset();
    set_ch(0, 127, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 127, "a127_high");
    phase(0, 1'b0, 127, "a127_low");
    phase(0, 1'b1, 127, "a127_high_b");

    // alpha=127 frac=15: 127, then fifteen 128s, then 127, then 128
    do_reset();
    set_ch(0, 127, 15, 1'b1, 1'b1);
    for (int k = 0; k < 18; k++) begin
      phase(0, (k % 2 == 0) ? 1'b1 : 1'b0, (k == 0 || k == 16) ? 127 : 128, "f15_half");
    end

    // Reset mid-HIGH clears every output at the next edge
    do_reset();
    set_ch(0, 10, 0, 1'b0, 1'b1);
    set_ch(1, 10, 0, 1'b0, 1'b1);
    phase(0, 1'b1, 3, "rst_pre_high");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_out", 32'(bus.clk_out), 32'd0);
    check("midrst_active", 32'(bus.active), 32'd0);
    check("midrst_upd", 32'(bus.upd), 32'd0);

    // Independence: ch0 alpha=2 integer, ch1 alpha=3 frac=4 -> 3,3,3,4 repeating
    set_ch(0, 2, 0, 1'b0, 1'b1);
    set_ch(1, 3, 4, 1'b1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("ind_upd_both", 32'(bus.upd), 32'd3);
    for (int c = 0; c < N; c++) begin
      lvl_q[c] = 1;
      idx_q[c] = 0;
      bad_q[c] = 0;
    end
    rem_q[0] = 2;
    rem_q[1] = 3;
    for (int t = 0; t < 56; t++) begin
      if (t != 0) @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (bus.clk_out[c] !== 1'(lvl_q[c])) bad_q[c]++;
        rem_q[c]--;
        if (rem_q[c] == 0) begin
          idx_q[c]++;
          lvl_q[c] = 1 - lvl_q[c];
          rem_q[c] = (c == 0) ? 2 : ((idx_q[c] % 4 == 3) ? 4 : 3);
        end
      end
    end
    check("ind_ch0_wave", 32'(bad_q[0]), 32'd0);
    check("ind_ch1_wave", 32'(bad_q[1]), 32'd0);
    check("ind_active_both", 32'(bus.active), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
